axi4_stream_downsizer: RTL and testbench

Parametrised AXI4-Stream width downsizer: accepts one wide input beat and emits it as `RATIO = IN_TDATA_WIDTH / OUT_TDATA_WIDTH` narrow lanes, least-significant lane first. It preserves packet boundaries and SOF marking, optionally skips null lanes, and sustains full throughput with no bubble between input beats. It sits between the frame buffer's wide memory-side streams and narrow pixel-side streams.

---
 rtl/axi4_stream_gbx_pkg.sv | 26 ++
 rtl/axi4_stream_if.sv | 30 +++
 rtl/lane_prio_enc.sv | 26 ++
 rtl/axi4_stream_downsizer.sv | 134 +++++++++++++
 tb/tb_axi4_stream_downsizer.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_stream_gbx_pkg.sv
// Shared helpers for the AXI4-Stream gearbox blocks: lane geometry, tuser
// mode encodings and the legality rule for a width pairing.
package axi4_stream_gbx_pkg;

  localparam int unsigned TUSER_SOF = 0;
  localparam int unsigned TUSER_ALL = 1;

  function automatic int unsigned lane_ratio(input int unsigned in_w,
                                             input int unsigned out_w);
    return (out_w == 0) ? 0 : in_w / out_w;
  endfunction

  function automatic int unsigned lane_idx_width(input int unsigned ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

  // Narrow side must be byte-aligned and the lane count a power of two >= 2.
  function automatic bit widths_legal(input int unsigned in_w,
                                      input int unsigned out_w);
    int unsigned r;
    if (out_w == 0 || (out_w % 8) != 0 || (in_w % out_w) != 0) return 1'b0;
    r = in_w / out_w;
    return (r >= 2) && ((r & (r - 1)) == 0);
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with master/slave views.
interface axi4_stream_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned DEST_WIDTH = 1,
  parameter int unsigned USER_WIDTH = 1
);
  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic [KEEP_WIDTH-1:0] tstrb;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport master (
    output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    output tready
  );

endinterface

// File: rtl/lane_prio_enc.sv
// Picks the lowest pending lane of a mask and flags when it is the only one left.
module lane_prio_enc
  import axi4_stream_gbx_pkg::*;
#(
  parameter int unsigned RATIO = 4
) (
  input  logic [RATIO-1:0]                      mask,
  output logic [lane_idx_width(RATIO)-1:0]      lane_idx_c,
  output logic [RATIO-1:0]                      lane_sel_c,
  output logic                                  last_lane_c
);

  localparam int unsigned IDX_W = lane_idx_width(RATIO);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    lane_idx_c = '0;
    for (int i = int'(RATIO) - 1; i >= 0; i--) begin
      if (mask[i]) lane_idx_c = IDX_W'(i);
    end
  end

  assign lane_sel_c  = mask & (~mask + RATIO'(1));
  assign last_lane_c = (mask != '0) && ((mask & (mask - RATIO'(1))) == '0);

endmodule

// File: rtl/axi4_stream_downsizer.sv
// Splits each wide AXI4-Stream beat into narrow lanes, lowest lane first,
// keeping packet boundaries and SOF marking with no bubble between beats.
module axi4_stream_downsizer
  import axi4_stream_gbx_pkg::*;
#(
  parameter int unsigned IN_TDATA_WIDTH  = 64,
  parameter int unsigned OUT_TDATA_WIDTH = 16,
  parameter int unsigned TID_WIDTH       = 1,
  parameter int unsigned TDEST_WIDTH     = 1,
  parameter int unsigned TUSER_WIDTH     = 1,
  parameter int unsigned TUSER_MODE      = TUSER_SOF,
  parameter int unsigned SKIP_NULL_LANES = 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  axi4_stream_if.slave  pkt_i,
  axi4_stream_if.master pkt_o
);

  localparam int unsigned RATIO   = lane_ratio(IN_TDATA_WIDTH, OUT_TDATA_WIDTH);
  localparam int unsigned IDX_W   = lane_idx_width(RATIO);
  localparam int unsigned LANE_KW = OUT_TDATA_WIDTH / 8;

  if (!widths_legal(IN_TDATA_WIDTH, OUT_TDATA_WIDTH)) begin : g_bad_width
    $error("axi4_stream_downsizer: illegal width pairing %0d -> %0d",
           IN_TDATA_WIDTH, OUT_TDATA_WIDTH);
  end
  if (TUSER_MODE > TUSER_ALL) begin : g_bad_tuser_mode
    $error("axi4_stream_downsizer: unknown TUSER_MODE %0d", TUSER_MODE);
  end

  logic [RATIO-1:0][OUT_TDATA_WIDTH-1:0] data_q;
  logic [RATIO-1:0][LANE_KW-1:0]         keep_q;
  logic [RATIO-1:0][LANE_KW-1:0]         strb_q;
  logic [TID_WIDTH-1:0]                  id_q;
  logic [TDEST_WIDTH-1:0]                dest_q;
  logic [TUSER_WIDTH-1:0]                user_q;
  logic                                  last_q;
  logic                                  null_q;
  logic                                  sof_q;
  logic                                  ready_en_q;
  logic [RATIO-1:0]                      mask_q;

  logic [RATIO-1:0][LANE_KW-1:0] in_keep_lanes;
  logic [RATIO-1:0]              kept_c;
  logic [RATIO-1:0]              mask_load_c;
  logic [IDX_W-1:0]              lane_idx_c;
  logic [RATIO-1:0]              lane_sel_c;
  logic                          last_lane_c;
  logic                          out_valid_c;
  logic                          out_last_c;
  logic                          in_ready_c;
  logic                          in_hs_c;
  logic                          out_hs_c;

  assign in_keep_lanes = pkt_i.tkeep;

  // Pending-lane mask for an incoming beat: kept lanes, or everything up to
  // the highest kept lane when null lanes are to be emitted.
  always_comb begin
    kept_c      = '0;
    mask_load_c = '0;
    for (int k = 0; k < int'(RATIO); k++) begin
      kept_c[k] = |in_keep_lanes[k];
    end
    for (int k = 0; k < int'(RATIO); k++) begin
      mask_load_c[k] = (SKIP_NULL_LANES != 0) ? kept_c[k] : |(kept_c >> k);
    end
  end

  lane_prio_enc #(
    .RATIO (RATIO)
  ) u_lane_prio_enc (
    .mask        (mask_q),
    .lane_idx_c  (lane_idx_c),
    .lane_sel_c  (lane_sel_c),
    .last_lane_c (last_lane_c)
  );

  // A pending null/tlast beat behaves as a single last lane.
  assign out_valid_c = (mask_q != '0) | null_q;
  assign out_last_c  = null_q | last_lane_c;
  assign in_ready_c  = ready_en_q & (~out_valid_c | (pkt_o.tready & out_last_c));
  assign in_hs_c     = pkt_i.tvalid & in_ready_c;
  assign out_hs_c    = out_valid_c & pkt_o.tready;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ready_en_q <= 1'b0;
    else          ready_en_q <= 1'b1;
  end

  // Beat buffer: a new beat overrides the retiring last lane on the same edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q <= '0;
      keep_q <= '0;
      strb_q <= '0;
      id_q   <= '0;
      dest_q <= '0;
      user_q <= '0;
      last_q <= 1'b0;
      null_q <= 1'b0;
      sof_q  <= 1'b0;
      mask_q <= '0;
    end else if (in_hs_c) begin
      data_q <= pkt_i.tdata;
      keep_q <= pkt_i.tkeep;
      strb_q <= pkt_i.tstrb;
      id_q   <= pkt_i.tid;
      dest_q <= pkt_i.tdest;
      user_q <= pkt_i.tuser;
      last_q <= pkt_i.tlast;
      null_q <= (pkt_i.tkeep == '0) & pkt_i.tlast;
      sof_q  <= 1'b1;
      mask_q <= mask_load_c;
    end else if (out_hs_c) begin
      mask_q <= mask_q & ~lane_sel_c;
      null_q <= 1'b0;
      sof_q  <= 1'b0;
    end
  end

  assign pkt_i.tready = in_ready_c;

  assign pkt_o.tvalid = out_valid_c;
  assign pkt_o.tdata  = data_q[lane_idx_c];
  assign pkt_o.tkeep  = keep_q[lane_idx_c];
  assign pkt_o.tstrb  = null_q ? '0 : strb_q[lane_idx_c];
  assign pkt_o.tlast  = last_q & out_last_c;
  assign pkt_o.tid    = id_q;
  assign pkt_o.tdest  = dest_q;
  assign pkt_o.tuser  = ((TUSER_MODE == TUSER_ALL) || sof_q) ? user_q : '0;

endmodule

// File: tb/tb_axi4_stream_downsizer.sv
// Bench for axi4_stream_downsizer: a default instance (skip null lanes, SOF
// tuser) and an alternate one (emit null lanes, tuser on every lane).
module tb_axi4_stream_downsizer;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic [7:0]  strb;
    logic        last;
    logic        id;
    logic        dest;
    logic        user;
  } beat_t;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  keep;
    logic [1:0]  strb;
    logic        last;
    logic        id;
    logic        dest;
    logic        user;
  } lane_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  beat_t in_beat = '0;
  logic in_ready;
  logic o_valid;
  lane_t obs;

  int errors = 0;
  int checks = 0;
  int out_count, out_first, out_last, run_cycles;
  logic [15:0] first_data;

  beat_t stim_q[$];
  lane_t exp_q[$];
  bit    end_q[$];

  always #5 clk = ~clk;

  axi4_stream_if #(.DATA_WIDTH(64)) in_m ();
  axi4_stream_if #(.DATA_WIDTH(64)) in_a ();
  axi4_stream_if #(.DATA_WIDTH(16)) out_m ();
  axi4_stream_if #(.DATA_WIDTH(16)) out_a ();

  assign in_m.tvalid = in_valid & ~sel;
  assign in_a.tvalid = in_valid & sel;
  assign in_m.tdata = in_beat.data;  assign in_a.tdata = in_beat.data;
  assign in_m.tkeep = in_beat.keep;  assign in_a.tkeep = in_beat.keep;
  assign in_m.tstrb = in_beat.strb;  assign in_a.tstrb = in_beat.strb;
  assign in_m.tlast = in_beat.last;  assign in_a.tlast = in_beat.last;
  assign in_m.tid   = in_beat.id;    assign in_a.tid   = in_beat.id;
  assign in_m.tdest = in_beat.dest;  assign in_a.tdest = in_beat.dest;
  assign in_m.tuser = in_beat.user;  assign in_a.tuser = in_beat.user;
  assign out_m.tready = out_ready & ~sel;
  assign out_a.tready = out_ready & sel;

  assign in_ready = sel ? in_a.tready : in_m.tready;
  assign o_valid  = sel ? out_a.tvalid : out_m.tvalid;
  assign obs = sel ?
    {out_a.tdata, out_a.tkeep, out_a.tstrb, out_a.tlast, out_a.tid, out_a.tdest, out_a.tuser} :
    {out_m.tdata, out_m.tkeep, out_m.tstrb, out_m.tlast, out_m.tid, out_m.tdest, out_m.tuser};

  axi4_stream_downsizer dut_main (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .pkt_i   (in_m),
    .pkt_o   (out_m)
  );

  axi4_stream_downsizer #(
    .TUSER_MODE      (1),
    .SKIP_NULL_LANES (0)
  ) dut_alt (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .pkt_i   (in_a),
    .pkt_o   (out_a)
  );

  // Reference: which 16-bit lanes a beat produces, from the lane rules alone.
  function automatic void expand(input beat_t b, input bit skip, input bit uall);
    int lanes[$];
    int hi;
    lane_t l;
    hi = -1;
    for (int k = 0; k < 4; k++) if (b.keep[2*k +: 2] != 2'b00) hi = k;
    if (hi < 0) begin
      if (b.last) begin
        l = '{data: b.data[15:0], keep: 2'b00, strb: 2'b00, last: 1'b1,
              id: b.id, dest: b.dest, user: b.user};
        exp_q.push_back(l);
        end_q.push_back(1'b1);
      end
      return;
    end
    for (int k = 0; k <= hi; k++) begin
      if (!skip || b.keep[2*k +: 2] != 2'b00) lanes.push_back(k);
    end
    for (int p = 0; p < lanes.size(); p++) begin
      l.data = b.data[16*lanes[p] +: 16];
      l.keep = b.keep[2*lanes[p] +: 2];
      l.strb = b.strb[2*lanes[p] +: 2];
      l.last = b.last && (p == lanes.size() - 1);
      l.id   = b.id;
      l.dest = b.dest;
      l.user = (uall || p == 0) ? b.user : 1'b0;
      exp_q.push_back(l);
      end_q.push_back(p == lanes.size() - 1);
    end
  endfunction

  function automatic beat_t mk(input logic [63:0] d, input logic [7:0] k,
                               input logic l, input logic u);
    beat_t b;
    b = '{data: d, keep: k, strb: k, last: l, id: 1'b0, dest: 1'b0, user: u};
    return b;
  endfunction

  function automatic beat_t rnd_beat();
    beat_t b;
    b.data = {$urandom, $urandom};
    b.keep = 8'($urandom);
    if ($urandom_range(0, 4) == 0) b.keep = 8'h00;
    b.strb = 8'($urandom);
    b.last = 1'($urandom);
    b.id   = 1'($urandom);
    b.dest = 1'($urandom);
    b.user = 1'($urandom);
    return b;
  endfunction

  // Streams stim_q into the selected DUT and scores every output lane.
  // rmode: 0 ready held high, 1 ready toggles 1,0,1,0, 2 random ready.
  task automatic run(input int rmode, input int budget);
    int cyc;
    bit stalled;
    lane_t held;
    lane_t e;
    bit uall, skip;
    cyc = 0; stalled = 0; held = '0;
    out_count = 0; out_first = -1; out_last = -1; first_data = 'x;
    skip = ~sel; uall = sel;
    while ((stim_q.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
      @(negedge clk);
      out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom);
      if (stim_q.size() != 0) begin
        in_beat = stim_q[0];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stalled) begin
        checks++;
        if (!o_valid || obs !== held) begin
          errors++;
          $display("FAIL hold_stable: got v=%b %h want v=1 %h", o_valid, obs, held);
        end
      end
      if (o_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_lane: got %h want no output", obs);
        end else begin
          e = exp_q[0];
          if (obs !== e) begin
            errors++;
            $display("FAIL lane: got %h want %h", obs, e);
          end
          checks++;
          if (in_ready !== (out_ready && end_q[0])) begin
            errors++;
            $display("FAIL in_ready_busy: got %b want %b", in_ready, out_ready && end_q[0]);
          end
          if (out_ready) begin
            if (out_first < 0) begin
              out_first = cyc;
              first_data = obs.data;
            end
            out_last = cyc;
            out_count++;
            void'(exp_q.pop_front());
            void'(end_q.pop_front());
          end
        end
      end else begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL in_ready_idle: got %b want 1", in_ready);
        end
      end
      stalled = o_valid && !out_ready;
      held = obs;
      if (in_valid && in_ready) begin
        expand(stim_q[0], skip, uall);
        void'(stim_q.pop_front());
      end
      cyc++;
    end
    run_cycles = cyc;
    in_valid = 1'b0;
    if (stim_q.size() != 0 || exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending lanes want 0", exp_q.size());
      stim_q.delete(); exp_q.delete(); end_q.delete();
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #2;
      checks++;
      if (o_valid !== 1'b0 || in_ready !== 1'b0 || obs.data !== 16'h0) begin
        errors++;
        $display("FAIL reset_state: got v=%b rdy=%b d=%h want 0 0 0000", o_valid, in_ready, obs.data);
      end
    end
    sel = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_edge: got %b want 1", in_ready);
    end
  endtask

  task automatic test_full_beat();
    sel = 1'b0;
    stim_q.push_back(mk(64'h4444_3333_2222_1111, 8'hFF, 1'b1, 1'b1));
    run(0, 20);
    checks++;
    if (out_count != 4 || out_last - out_first != 3) begin
      errors++;
      $display("FAIL full_beat_count: got %0d in %0d cycles want 4 in 4", out_count, out_last - out_first + 1);
    end
  endtask

  task automatic test_tail_sparse();
    sel = 1'b0;
    stim_q.push_back(mk(64'h4444_3333_2222_1111, 8'h0F, 1'b1, 1'b0));
    run(0, 20);
    checks++;
    if (out_count != 2) begin
      errors++;
      $display("FAIL tail_count: got %0d want 2", out_count);
    end
    stim_q.push_back(mk(64'h4444_3333_2222_1111, 8'hC3, 1'b0, 1'b1));
    run(0, 20);
    checks++;
    if (out_count != 2 || first_data !== 16'h1111) begin
      errors++;
      $display("FAIL sparse_count: got %0d first %h want 2 first 1111", out_count, first_data);
    end
  endtask

  task automatic test_skip_off();
    sel = 1'b1;
    stim_q.push_back(mk(64'h4444_3333_2222_1111, 8'hC3, 1'b1, 1'b0));
    run(0, 20);
    checks++;
    if (out_count != 4) begin
      errors++;
      $display("FAIL skip_off_count: got %0d want 4", out_count);
    end
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    stim_q.push_back(mk(64'h4444_3333_2222_1111, 8'hFF, 1'b0, 1'b1));
    stim_q.push_back(mk(64'h8888_7777_6666_5555, 8'hFF, 1'b1, 1'b0));
    run(0, 30);
    checks++;
    if (out_count != 8 || out_last - out_first != 7) begin
      errors++;
      $display("FAIL back_to_back: got %0d in %0d cycles want 8 in 8", out_count, out_last - out_first + 1);
    end
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    stim_q.push_back(mk(64'hDDDD_CCCC_BBBB_AAAA, 8'hFF, 1'b0, 1'b1));
    stim_q.push_back(mk(64'h1234_5678_9ABC_DEF0, 8'hFF, 1'b1, 1'b0));
    run(1, 40);
    checks++;
    if (out_count != 8) begin
      errors++;
      $display("FAIL backpressure_count: got %0d want 8", out_count);
    end
  endtask

  task automatic test_null_beats();
    beat_t b;
    sel = 1'b0;
    stim_q.push_back(mk(64'hFEED_FACE_CAFE_BEEF, 8'h00, 1'b0, 1'b1));
    run(0, 10);
    checks++;
    if (out_count != 0 || run_cycles != 1) begin
      errors++;
      $display("FAIL null_no_last: got %0d outputs %0d cycles want 0 outputs 1 cycle", out_count, run_cycles);
    end
    @(negedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL null_no_last_idle: got rdy=%b v=%b want 1 0", in_ready, o_valid);
    end
    b = mk(64'hFEED_FACE_CAFE_BEEF, 8'h00, 1'b1, 1'b1);
    b.strb = 8'hFF;
    stim_q.push_back(b);
    run(0, 10);
    checks++;
    if (out_count != 1) begin
      errors++;
      $display("FAIL null_last_count: got %0d want 1", out_count);
    end
  endtask

  task automatic test_tuser_all();
    beat_t b;
    sel = 1'b1;
    b = mk(64'h4444_3333_2222_1111, 8'hFF, 1'b1, 1'b1);
    b.id = 1'b1;
    b.dest = 1'b1;
    stim_q.push_back(b);
    run(1, 20);
    checks++;
    if (out_count != 4) begin
      errors++;
      $display("FAIL tuser_all_count: got %0d want 4", out_count);
    end
    sel = 1'b0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      sel = 1'($urandom);
      for (int i = 0; i < 12; i++) stim_q.push_back(rnd_beat());
      run(2, 400);
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_midbeat();
    sel = 1'b0;
    @(negedge clk);
    in_beat = mk(64'h4444_3333_2222_1111, 8'hFF, 1'b1, 1'b0);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b1 || obs.data !== 16'h1111) begin
      errors++;
      $display("FAIL midbeat_first: got v=%b d=%h want 1 1111", o_valid, obs.data);
    end
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (obs.data !== 16'h3333) begin
      errors++;
      $display("FAIL midbeat_third: got %h want 3333", obs.data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%b rdy=%b want 0 0", o_valid, in_ready);
    end
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL release_ready: got rdy=%b v=%b want 0 0", in_ready, o_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready_edge: got %b want 1", in_ready);
    end
    exp_q.delete();
    end_q.delete();
    stim_q.push_back(mk(64'h8888_7777_6666_5555, 8'hFF, 1'b1, 1'b1));
    run(0, 20);
    checks++;
    if (first_data !== 16'h5555 || out_count != 4) begin
      errors++;
      $display("FAIL post_reset_beat: got first %h count %0d want 5555 4", first_data, out_count);
    end
  endtask

  initial begin
    test_reset();
    test_full_beat();
    test_tail_sparse();
    test_skip_off();
    test_back_to_back();
    test_backpressure();
    test_null_beats();
    test_tuser_all();
    test_random();
    test_reset_midbeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
